// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract unit. Each clock, one CHUNK-bit ripple slice of
// the latched operands is summed and the carry is held in a register between
// slices, so the per-cycle carry path is only CHUNK full adders long.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTEP = WIDTH / CHUNK;
  localparam int KW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, partial, partial_next;
  logic             carry;
  logic [KW-1:0]    k;
  logic             last;
  logic [CHUNK+1:0] slice;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout, slice_cmsb;

  // Ripple of CHUNK full adders. Returns {carry into top bit, carry out, sum}.
  // The carry into the top bit only matters on the final slice, where it is
  // the carry into the operand MSB used for signed overflow.
  function automatic logic [CHUNK+1:0] slice_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
    logic             c;
    logic             cm;
    logic [CHUNK-1:0] s;
    c  = ci;
    cm = ci;
    s  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cm   = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {cm, c, s};
  endfunction

  // Operands are shifted right each step, so the active slice is always the
  // low CHUNK bits; the sum slice enters the partial register from the top.
  assign slice = slice_add(op_a[CHUNK-1:0], op_b[CHUNK-1:0], carry);
  assign {slice_cmsb, slice_cout, slice_sum} = slice;
  assign partial_next = (partial >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
  assign last = (k == KW'(NSTEP - 1));
  assign busy = (state == RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: start only honoured in IDLE, leave RUN after last slice.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, per-slice accumulation and result/flag update at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      partial <= '0;
      carry   <= 1'b0;
      k       <= '0;
      q       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            k     <= '0;
          end
        end
        RUN: begin
          op_a    <= op_a >> CHUNK;
          op_b    <= op_b >> CHUNK;
          partial <= partial_next;
          carry   <= slice_cout;
          k       <= k + 1'b1;
          if (last) begin
            q    <= partial_next;
            cout <= slice_cout;
            ovf  <= slice_cmsb ^ slice_cout;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
